// File: rtl/ysyx_25020047_pkg.sv
// Shared types for the RV32E multi-cycle sequencer: state/stage codes,
// decode-flag bundle and the instruction-type one-hot codes.
package ysyx_25020047_pkg;

  localparam int unsigned STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // One-hot instruction class, shared with decode and writeback muxing
  typedef enum logic [5:0] {
    INST_R = 6'b000001,
    INST_I = 6'b000010,
    INST_S = 6'b000100,
    INST_B = 6'b001000,
    INST_U = 6'b010000,
    INST_J = 6'b100000
  } inst_type_e;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic wb;
    logic ebreak;
    logic illegal;
  } dec_info_t;

  // A load that is also a store has no valid meaning and is rejected
  function automatic logic dec_is_bad(input dec_info_t d);
    return d.illegal | (d.is_load & d.is_store);
  endfunction

endpackage

// File: rtl/ysyx_25020047_wait_timer.sv
// Bus-wait counter: o_hit_c flags the LIMIT-th consecutive enabled cycle.
// LIMIT of 0 disables the timeout entirely.
module ysyx_25020047_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit_c
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit_c = (LIMIT != 0) && i_en && (r_cnt == LAST);

endmodule

// File: rtl/ysyx_25020047_cpu_seq.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> (MEM) -> WB, with
// bus-wait timeout, halt on ebreak/illegal, and cycle/instret counters.
module ysyx_25020047_cpu_seq
  import ysyx_25020047_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ifu_req,
  input  logic               ifu_ack,
  output logic               inst_latch,
  input  logic               inst_is_load,
  input  logic               inst_is_store,
  input  logic               inst_wb,
  input  logic               inst_ebreak,
  input  logic               inst_illegal,
  output logic               lsu_req,
  output logic               lsu_wen,
  input  logic               lsu_ack,
  output logic               rf_wen,
  output logic               pc_wen,
  output logic               halted,
  output logic               bus_err,
  output logic [STAGE_W-1:0] stage,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
);

  state_e           r_state;
  logic             r_is_store;
  logic             r_wb;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret_cnt;

  dec_info_t        w_dec;
  logic             w_in_fetch;
  logic             w_in_mem;
  logic             w_wait;
  logic             w_ack;
  logic             w_hit;
  logic             w_active;

  assign w_dec      = {inst_is_load, inst_is_store, inst_wb, inst_ebreak, inst_illegal};
  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_in_mem   = (r_state == ST_MEM);
  assign w_wait     = w_in_fetch | w_in_mem;
  // Each ack only counts while its own request is being driven
  assign w_ack      = (w_in_fetch & ifu_ack) | (w_in_mem & lsu_ack);
  assign w_active   = (r_state == ST_FETCH) | (r_state == ST_DECODE) |
                      (r_state == ST_MEM)   | (r_state == ST_WB);

  ysyx_25020047_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (~w_wait),
    .i_en    (w_wait & ~w_ack),
    .o_hit_c (w_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RESET;
      r_is_store    <= 1'b0;
      r_wb          <= 1'b0;
      r_bus_err     <= 1'b0;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (w_active) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      case (r_state)
        ST_RESET: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (ifu_ack) begin
            r_state <= ST_DECODE;
          end else if (w_hit) begin
            r_state   <= ST_HALT;
            r_bus_err <= 1'b1;
          end
        end
        ST_DECODE: begin
          r_is_store <= w_dec.is_store;
          r_wb       <= w_dec.wb;
          if (dec_is_bad(w_dec)) begin
            r_state   <= ST_HALT;
            r_bus_err <= 1'b1;
          end else if (w_dec.ebreak) begin
            r_state <= ST_HALT;
          end else if (w_dec.is_load || w_dec.is_store) begin
            r_state <= ST_MEM;
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (lsu_ack) begin
            r_state <= ST_WB;
          end else if (w_hit) begin
            r_state   <= ST_HALT;
            r_bus_err <= 1'b1;
          end
        end
        ST_WB: begin
          r_instret_cnt <= r_instret_cnt + CNT_W'(1);
          r_state       <= ST_FETCH;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RESET;
      endcase
    end
  end

  // Strobes decode the state register; a reset cycle suppresses them all
  assign ifu_req     = ~rst & w_in_fetch;
  assign inst_latch  = ifu_req & ifu_ack;
  assign lsu_req     = ~rst & w_in_mem;
  assign lsu_wen     = lsu_req & r_is_store;
  assign pc_wen      = ~rst & (r_state == ST_WB);
  assign rf_wen      = pc_wen & r_wb & ~r_is_store;
  assign halted      = (r_state == ST_HALT);
  assign bus_err     = r_bus_err;
  assign stage       = r_state;
  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_ysyx_25020047_cpu_seq.sv
// Directed-vector bench for the sequencer: per-cycle expected snapshots are
// queued by the stimulus and popped/compared by an independent monitor.
module tb_ysyx_25020047_cpu_seq;

  localparam int unsigned TO = 8;

  // Strobe vector order: ifu_req inst_latch lsu_req lsu_wen rf_wen pc_wen halted bus_err
  localparam logic [7:0] NONE  = 8'b0000_0000;
  localparam logic [7:0] IFU   = 8'b1000_0000;
  localparam logic [7:0] LATCH = 8'b0100_0000;
  localparam logic [7:0] LREQ  = 8'b0010_0000;
  localparam logic [7:0] LWEN  = 8'b0001_0000;
  localparam logic [7:0] RFW   = 8'b0000_1000;
  localparam logic [7:0] PCW   = 8'b0000_0100;
  localparam logic [7:0] HLT   = 8'b0000_0010;
  localparam logic [7:0] BERR  = 8'b0000_0001;

  typedef struct packed {
    logic [2:0]  stage;
    logic [7:0]  sb;
    logic [31:0] cyc;
    logic [31:0] ins;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, ifu_ack, inst_latch;
  logic        inst_is_load, inst_is_store, inst_wb, inst_ebreak, inst_illegal;
  logic        lsu_req, lsu_wen, lsu_ack;
  logic        rf_wen, pc_wen, halted, bus_err;
  logic [2:0]  stage;
  logic [31:0] cycle_cnt, instret_cnt;

  snap_t       exp_q[$];
  string       tag_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [31:0] e_cyc  = 0;
  logic [31:0] e_ins  = 0;

  always #5 clk = ~clk;

  ysyx_25020047_cpu_seq #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req       (ifu_req),
    .ifu_ack       (ifu_ack),
    .inst_latch    (inst_latch),
    .inst_is_load  (inst_is_load),
    .inst_is_store (inst_is_store),
    .inst_wb       (inst_wb),
    .inst_ebreak   (inst_ebreak),
    .inst_illegal  (inst_illegal),
    .lsu_req       (lsu_req),
    .lsu_wen       (lsu_wen),
    .lsu_ack       (lsu_ack),
    .rf_wen        (rf_wen),
    .pc_wen        (pc_wen),
    .halted        (halted),
    .bus_err       (bus_err),
    .stage         (stage),
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt)
  );

  // Monitor: every checked cycle, pop one expected snapshot and compare
  always @(negedge clk) begin
    snap_t a, e;
    string t;
    if (mon_en) begin
      a.stage = stage;
      a.sb    = {ifu_req, inst_latch, lsu_req, lsu_wen, rf_wen, pc_wen, halted, bus_err};
      a.cyc   = cycle_cnt;
      a.ins   = instret_cnt;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL trace_underrun: got stage=%0d strobes=%b with no expected entry", a.stage, a.sb);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got stage=%0d strobes=%b cyc=%0d ins=%0d, want stage=%0d strobes=%b cyc=%0d ins=%0d",
                   t, a.stage, a.sb, a.cyc, a.ins, e.stage, e.sb, e.cyc, e.ins);
        end
      end
    end
  end

  task automatic idle();
    ifu_ack = 0; lsu_ack = 0;
    inst_is_load = 0; inst_is_store = 0; inst_wb = 0; inst_ebreak = 0; inst_illegal = 0;
  endtask

  // Queue the expected view of the current cycle, then advance one clock
  task automatic cyc(input string tag, input logic [2:0] st, input logic [7:0] sb);
    snap_t e;
    e.stage = st; e.sb = sb; e.cyc = e_cyc; e.ins = e_ins;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    if (rst) begin
      e_cyc = 0; e_ins = 0;
    end else begin
      if (st >= 3'd1 && st <= 3'd4) e_cyc = e_cyc + 1;
      if (st == 3'd4) e_ins = e_ins + 1;
    end
    idle();
  endtask

  task automatic fetch_now(input string tag);
    ifu_ack = 1;
    cyc(tag, 3'd1, IFU | LATCH);
  endtask

  task automatic do_reset(input string tag, input logic [2:0] st, input logic [7:0] sb);
    rst = 1;
    cyc(tag, st, sb);
    rst = 0;
    cyc({tag, "_reset_state"}, 3'd0, NONE);
  endtask

  initial begin
    rst = 1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    mon_en = 1;
    cyc("reset_state", 3'd0, NONE);

    // addi, zero-wait; stray lsu_ack during FETCH must be ignored
    ifu_ack = 1; lsu_ack = 1;
    cyc("addi_fetch", 3'd1, IFU | LATCH);
    inst_wb = 1;
    cyc("addi_decode", 3'd2, NONE);
    cyc("addi_wb", 3'd4, RFW | PCW);

    // lw, lsu_ack after 5 wait cycles; stray ifu_ack during MEM ignored
    fetch_now("lw_fetch");
    inst_is_load = 1; inst_wb = 1;
    cyc("lw_decode", 3'd2, NONE);
    for (int i = 0; i < 5; i++) begin
      ifu_ack = 1;
      cyc($sformatf("lw_mem_wait%0d", i), 3'd3, LREQ);
    end
    lsu_ack = 1;
    cyc("lw_mem_ack", 3'd3, LREQ);
    cyc("lw_wb", 3'd4, RFW | PCW);

    // store with inst_wb=1: lsu_wen throughout MEM, no rf_wen in WB
    fetch_now("sw_fetch");
    inst_is_store = 1; inst_wb = 1;
    cyc("sw_decode", 3'd2, NONE);
    cyc("sw_mem0", 3'd3, LREQ | LWEN);
    cyc("sw_mem1", 3'd3, LREQ | LWEN);
    lsu_ack = 1;
    cyc("sw_mem_ack", 3'd3, LREQ | LWEN);
    cyc("sw_wb", 3'd4, PCW);

    // ifu_ack exactly on the timeout-limit cycle wins
    for (int i = 0; i < int'(TO) - 1; i++) cyc($sformatf("late_fetch_wait%0d", i), 3'd1, IFU);
    fetch_now("late_fetch_ack");
    cyc("late_decode", 3'd2, NONE);
    cyc("late_wb", 3'd4, PCW);

    // reset mid MEM wait, with an lsu_ack arriving during and after reset
    fetch_now("rst_fetch");
    inst_is_load = 1; inst_wb = 1;
    cyc("rst_decode", 3'd2, NONE);
    cyc("rst_mem_wait", 3'd3, LREQ);
    rst = 1; lsu_ack = 1;
    cyc("rst_in_mem", 3'd3, NONE);
    rst = 0; lsu_ack = 1;
    cyc("rst_after_mem", 3'd0, NONE);
    lsu_ack = 1;
    cyc("rst_fetch_ignores_lsu_ack", 3'd1, IFU);

    // ebreak: halt without error, no pc_wen, counters frozen
    fetch_now("ebreak_fetch");
    inst_ebreak = 1; inst_wb = 1;
    cyc("ebreak_decode", 3'd2, NONE);
    ifu_ack = 1;
    cyc("ebreak_halt0", 3'd5, HLT);
    cyc("ebreak_halt1", 3'd5, HLT);
    do_reset("ebreak_rst", 3'd5, HLT);

    // illegal instruction: halt with bus_err
    fetch_now("illegal_fetch");
    inst_illegal = 1; inst_ebreak = 1;
    cyc("illegal_decode", 3'd2, NONE);
    cyc("illegal_halt0", 3'd5, HLT | BERR);
    cyc("illegal_halt1", 3'd5, HLT | BERR);
    do_reset("illegal_rst", 3'd5, HLT | BERR);

    // load and store both set is treated as illegal
    fetch_now("ldst_fetch");
    inst_is_load = 1; inst_is_store = 1;
    cyc("ldst_decode", 3'd2, NONE);
    cyc("ldst_halt", 3'd5, HLT | BERR);
    do_reset("ldst_rst", 3'd5, HLT | BERR);

    // fetch timeout: TO cycles with no ack, then halt with bus_err
    for (int i = 0; i < int'(TO); i++) cyc($sformatf("to_fetch_wait%0d", i), 3'd1, IFU);
    cyc("to_halt0", 3'd5, HLT | BERR);
    ifu_ack = 1;
    cyc("to_halt1", 3'd5, HLT | BERR);
    cyc("to_halt2", 3'd5, HLT | BERR);

    mon_en = 0;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL trace_drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
